// File: rtl/pilot_insert.sv
// pilot_insert: builds 64-carrier OFDM symbols in IFFT input order.
// Data carriers take samples from the mapper stream, pilot carriers get
// +/-PILOT_AMP with polarity from the 127-length p_n sequence, and null
// carriers are emitted as zero. Both sides use a Wishbone-style handshake.
module pilot_insert #(
  parameter int                 NCAR      = 64,
  parameter logic signed [15:0] PILOT_AMP = 16'sh2000
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [31:0]         DAT_I,
  input  logic                CYC_I,
  input  logic                WE_I,
  input  logic                STB_I,
  output logic                ACK_O,
  output logic [31:0]         DAT_O,
  output logic                WE_O,
  output logic                STB_O,
  output logic                CYC_O,
  input  logic                ACK_I,
  input  logic [2*NCAR-1:0]   ALLOC_VEC,
  output logic                VEC_LD
);

  localparam int KW = $clog2(NCAR);

  // Carrier map codes
  localparam logic [1:0] CODE_NULL = 2'b00;
  localparam logic [1:0] CODE_POS  = 2'b01;
  localparam logic [1:0] CODE_NEG  = 2'b10;
  localparam logic [1:0] CODE_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2*NCAR-1:0] map;
  logic [KW-1:0]     k;
  logic [6:0]        lfsr;

  logic              out_rdy;
  logic              fb;
  logic              last_car;
  logic [1:0]        code;
  logic              produce;
  logic [31:0]       sample;

  // Pilot word on the Re rail; negation is done at 16 bits with no saturation.
  function automatic logic [15:0] pilot_word(input logic neg);
    logic [15:0] val;
    if (neg) begin
      val = 16'(-PILOT_AMP);
    end else begin
      val = PILOT_AMP;
    end
    return val;
  endfunction

  assign out_rdy  = !STB_O || ACK_I;
  assign fb       = lfsr[6] ^ lfsr[3];
  assign last_car = (k == KW'(NCAR - 1));
  assign code     = map[{k, 1'b0} +: 2];
  assign WE_O     = STB_O;

  // State register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: frame start, symbol completion, padding and drain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (CYC_I) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!CYC_I && (k == KW'(0))) begin
          state_nxt = DRAIN;
        end else if (!CYC_I) begin
          state_nxt = PAD;
        end else begin
          state_nxt = RUN;
        end
      end
      PAD: begin
        if (produce && last_car) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = PAD;
        end
      end
      DRAIN: begin
        if (out_rdy) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: input acknowledge, whether a carrier is produced, and its value
  always_comb begin
    ACK_O   = 1'b0;
    produce = 1'b0;
    sample  = 32'd0;
    case (state)
      RUN: begin
        if (CYC_I) begin
          case (code)
            CODE_DATA: begin
              if (STB_I && WE_I && out_rdy) begin
                ACK_O   = 1'b1;
                produce = 1'b1;
                sample  = DAT_I;
              end else begin
                produce = 1'b0;
              end
            end
            CODE_POS, CODE_NEG: begin
              produce = out_rdy;
              sample  = {16'd0, pilot_word(code[1] ^ fb)};
            end
            default: begin
              produce = out_rdy;
              sample  = 32'd0;
            end
          endcase
        end else begin
          produce = 1'b0;
        end
      end
      PAD: begin
        produce = out_rdy;
        if ((code == CODE_POS) || (code == CODE_NEG)) begin
          sample = {16'd0, pilot_word(code[1] ^ fb)};
        end else begin
          sample = 32'd0;
        end
      end
      default: begin
        produce = 1'b0;
      end
    endcase
  end

  // Datapath: map latch, carrier index, LFSR, and the registered output stage
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      map    <= {(2*NCAR){1'b0}};
      k      <= KW'(0);
      lfsr   <= 7'h7F;
      DAT_O  <= 32'd0;
      STB_O  <= 1'b0;
      CYC_O  <= 1'b0;
      VEC_LD <= 1'b0;
    end else begin
      VEC_LD <= 1'b0;
      case (state)
        IDLE: begin
          if (CYC_I) begin
            map    <= ALLOC_VEC;
            VEC_LD <= 1'b1;
            k      <= KW'(0);
            lfsr   <= 7'h7F;
          end
        end
        RUN, PAD: begin
          if (produce) begin
            DAT_O <= sample;
            STB_O <= 1'b1;
            CYC_O <= 1'b1;
            if (last_car) begin
              k    <= KW'(0);
              lfsr <= {lfsr[5:0], fb};
            end else begin
              k <= k + KW'(1);
            end
          end else if (out_rdy) begin
            STB_O <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_rdy) begin
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
